// File: rtl/cpx_dot_prod_acc.sv
// Complex dot-product accumulator: multiplies x by y or by conj(y), sums
// `length` products per frame and emits one scaled, saturated result.
module cpx_dot_prod_acc #(
    parameter int xi_bits             = 12,
    parameter int xq_bits             = 12,
    parameter int yi_bits             = 12,
    parameter int yq_bits             = 12,
    parameter int length              = 5,
    parameter int length_counter_size = 3,
    parameter int sum_i_size          = 32,
    parameter int sum_q_size          = 32,
    parameter int out_i_bits          = 24,
    parameter int out_q_bits          = 24,
    parameter int out_shift           = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_axis_x_tvalid,
    input  logic [xi_bits-1:0]    xi,
    input  logic [xq_bits-1:0]    xq,
    input  logic                  m_axis_y_tvalid,
    input  logic [yi_bits-1:0]    yi,
    input  logic [yq_bits-1:0]    yq,
    input  logic                  conj_y,
    output logic                  s_axis_xy_tready,
    input  logic                  m_axis_product_tready,
    output logic                  s_axis_product_tvalid,
    output logic [out_i_bits-1:0] i,
    output logic [out_q_bits-1:0] q,
    output logic                  sat
);

    localparam int W_II = xi_bits + yi_bits;
    localparam int W_QQ = xq_bits + yq_bits;
    localparam int PW   = ((W_II > W_QQ) ? W_II : W_QQ) + 1;
    localparam int LCW  = length_counter_size;

    localparam logic [LCW-1:0] LAST = LCW'(length - 1);
    localparam logic [LCW-1:0] ONE  = LCW'(1);

    localparam logic signed [sum_i_size-1:0] I_MAX =
        {{(sum_i_size - out_i_bits + 1){1'b0}}, {(out_i_bits - 1){1'b1}}};
    localparam logic signed [sum_i_size-1:0] I_MIN = ~I_MAX;
    localparam logic signed [sum_q_size-1:0] Q_MAX =
        {{(sum_q_size - out_q_bits + 1){1'b0}}, {(out_q_bits - 1){1'b1}}};
    localparam logic signed [sum_q_size-1:0] Q_MIN = ~Q_MAX;

    // Handshake and frame bookkeeping
    logic           accept;
    logic           last_in;
    logic           out_hs;
    logic           frame_end;
    logic [LCW-1:0] in_cnt;
    logic [LCW-1:0] cnt;
    logic           outstanding;

    // Stage 1: registered operands
    logic                 s1_v;
    logic                 s1_conj;
    logic signed [PW-1:0] s1_xi;
    logic signed [PW-1:0] s1_xq;
    logic signed [PW-1:0] s1_yi;
    logic signed [PW-1:0] s1_yq;

    // Stage 2: partial products
    logic                 s2_v;
    logic                 s2_conj;
    logic signed [PW-1:0] s2_ii;
    logic signed [PW-1:0] s2_qq;
    logic signed [PW-1:0] s2_iq;
    logic signed [PW-1:0] s2_qi;

    // Stage 3: complex product
    logic                 s3_v;
    logic signed [PW-1:0] s3_pi;
    logic signed [PW-1:0] s3_pq;

    // Accumulation and output scaling
    logic signed [sum_i_size-1:0] acc_i;
    logic signed [sum_q_size-1:0] acc_q;
    logic signed [sum_i_size-1:0] base_i;
    logic signed [sum_q_size-1:0] base_q;
    logic signed [sum_i_size-1:0] sum_i;
    logic signed [sum_q_size-1:0] sum_q;
    logic signed [sum_i_size-1:0] sh_i;
    logic signed [sum_q_size-1:0] sh_q;
    logic                         hi_i;
    logic                         lo_i;
    logic                         hi_q;
    logic                         lo_q;
    logic [out_i_bits-1:0]        res_i;
    logic [out_q_bits-1:0]        res_q;

    assign out_hs    = s_axis_product_tvalid && m_axis_product_tready;
    assign accept    = m_axis_x_tvalid && m_axis_y_tvalid && s_axis_xy_tready;
    assign last_in   = accept && (in_cnt == LAST);
    assign frame_end = s3_v && (cnt == LAST);

    // Hold off a frame's last pair while the previous result is unclaimed
    assign s_axis_xy_tready = !((in_cnt == LAST) && outstanding && !out_hs);

    assign base_i = (cnt == '0) ? '0 : acc_i;
    assign base_q = (cnt == '0) ? '0 : acc_q;
    assign sum_i  = base_i + sum_i_size'(s3_pi);
    assign sum_q  = base_q + sum_q_size'(s3_pq);
    assign sh_i   = sum_i >>> out_shift;
    assign sh_q   = sum_q >>> out_shift;

    assign hi_i = sh_i > I_MAX;
    assign lo_i = sh_i < I_MIN;
    assign hi_q = sh_q > Q_MAX;
    assign lo_q = sh_q < Q_MIN;

    always_comb begin
        res_i = sh_i[out_i_bits-1:0];
        res_q = sh_q[out_q_bits-1:0];
        if (hi_i) res_i = I_MAX[out_i_bits-1:0];
        if (lo_i) res_i = I_MIN[out_i_bits-1:0];
        if (hi_q) res_q = Q_MAX[out_q_bits-1:0];
        if (lo_q) res_q = Q_MIN[out_q_bits-1:0];
    end

    // Datapath registers only move under their stage valid
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_xi   <= PW'($signed(xi));
            s1_xq   <= PW'($signed(xq));
            s1_yi   <= PW'($signed(yi));
            s1_yq   <= PW'($signed(yq));
            s1_conj <= conj_y;
        end
        if (s1_v) begin
            s2_ii   <= s1_xi * s1_yi;
            s2_qq   <= s1_xq * s1_yq;
            s2_iq   <= s1_xi * s1_yq;
            s2_qi   <= s1_xq * s1_yi;
            s2_conj <= s1_conj;
        end
        if (s2_v) begin
            s3_pi <= s2_conj ? (s2_ii + s2_qq) : (s2_ii - s2_qq);
            s3_pq <= s2_conj ? (s2_qi - s2_iq) : (s2_iq + s2_qi);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v                  <= 1'b0;
            s2_v                  <= 1'b0;
            s3_v                  <= 1'b0;
            cnt                   <= '0;
            in_cnt                <= '0;
            outstanding           <= 1'b0;
            acc_i                 <= '0;
            acc_q                 <= '0;
            i                     <= '0;
            q                     <= '0;
            sat                   <= 1'b0;
            s_axis_product_tvalid <= 1'b0;
        end else begin
            s1_v <= accept;
            s2_v <= s1_v;
            s3_v <= s2_v;

            if (accept) begin
                in_cnt <= last_in ? '0 : in_cnt + ONE;
            end

            if (last_in) begin
                outstanding <= 1'b1;
            end else if (out_hs) begin
                outstanding <= 1'b0;
            end

            if (s3_v) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= frame_end ? '0 : cnt + ONE;
            end

            // A new frame end wins over the handshake of the old result
            if (frame_end) begin
                i                     <= res_i;
                q                     <= res_q;
                sat                   <= hi_i || lo_i || hi_q || lo_q;
                s_axis_product_tvalid <= 1'b1;
            end else if (out_hs) begin
                s_axis_product_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpx_dot_prod_acc.sv
// Bench for cpx_dot_prod_acc: directed frame table, reset and back-pressure
// sequences, and random traffic against a frame-level scoreboard.
module tb_cpx_dot_prod_acc;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        xv = 1'b0;
    logic        yv = 1'b0;
    logic        cj = 1'b0;
    logic        ptr = 1'b1;
    logic [11:0] xi = '0;
    logic [11:0] xq = '0;
    logic [11:0] yi = '0;
    logic [11:0] yq = '0;

    logic        a_rdy, a_v, a_s;
    logic [23:0] a_i, a_q;
    logic        b_rdy, b_v, b_s;
    logic [15:0] b_i, b_q;
    logic        c_rdy, c_v, c_s;
    logic [23:0] c_i, c_q;

    // a: defaults; b: 16-bit outputs with >>>4; c: two-product frames
    cpx_dot_prod_acc u_a (
        .clk(clk), .reset(reset),
        .m_axis_x_tvalid(xv), .xi(xi), .xq(xq),
        .m_axis_y_tvalid(yv), .yi(yi), .yq(yq),
        .conj_y(cj), .s_axis_xy_tready(a_rdy),
        .m_axis_product_tready(ptr), .s_axis_product_tvalid(a_v),
        .i(a_i), .q(a_q), .sat(a_s)
    );

    cpx_dot_prod_acc #(
        .out_i_bits(16), .out_q_bits(16), .out_shift(4)
    ) u_b (
        .clk(clk), .reset(reset),
        .m_axis_x_tvalid(xv), .xi(xi), .xq(xq),
        .m_axis_y_tvalid(yv), .yi(yi), .yq(yq),
        .conj_y(cj), .s_axis_xy_tready(b_rdy),
        .m_axis_product_tready(ptr), .s_axis_product_tvalid(b_v),
        .i(b_i), .q(b_q), .sat(b_s)
    );

    cpx_dot_prod_acc #(
        .length(2), .length_counter_size(1)
    ) u_c (
        .clk(clk), .reset(reset),
        .m_axis_x_tvalid(xv), .xi(xi), .xq(xq),
        .m_axis_y_tvalid(yv), .yi(yi), .yq(yq),
        .conj_y(cj), .s_axis_xy_tready(c_rdy),
        .m_axis_product_tready(ptr), .s_axis_product_tvalid(c_v),
        .i(c_i), .q(c_q), .sat(c_s)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: frame sums in plain integer arithmetic per instance
    typedef struct {
        longint i;
        longint q;
        bit     s;
    } res_t;

    int     plen[ND] = '{5, 5, 2};
    int     pob[ND]  = '{24, 16, 24};
    int     psh[ND]  = '{0, 4, 0};
    longint m_si[ND];
    longint m_sq[ND];
    int     m_n[ND];
    res_t   q0[$];
    res_t   q1[$];
    res_t   q2[$];

    task automatic qpush(input int d, input res_t r);
        case (d)
            0: q0.push_back(r);
            1: q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endtask

    task automatic qpop(input int d, output res_t r, output bit ok);
        ok = 1'b1;
        case (d)
            0: if (q0.size() > 0) r = q0.pop_front(); else ok = 1'b0;
            1: if (q1.size() > 0) r = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) r = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    function automatic longint clampv(input longint v, input int ob, output bit s);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (ob - 1)) - 1;
        lo = -hi - 1;
        s  = 1'b0;
        if (v > hi) begin s = 1'b1; return hi; end
        if (v < lo) begin s = 1'b1; return lo; end
        return v;
    endfunction

    task automatic sb_step(input int d, input bit acc, input bit hs,
                           input longint oi, input longint oq, input bit os);
        res_t   r;
        bit     ok;
        bit     si, sq;
        longint a, b, c, e, pi, pq;
        if (hs) begin
            qpop(d, r, ok);
            if (!ok) begin
                vectors++;
                miscompares++;
                $display("FAIL sb%0d_extra: got result %0d/%0d, expected none", d, oi, oq);
            end else begin
                check($sformatf("sb%0d_i", d), oi, r.i);
                check($sformatf("sb%0d_q", d), oq, r.q);
                check($sformatf("sb%0d_sat", d), longint'(os), longint'(r.s));
            end
        end
        if (acc) begin
            a = $signed(xi);
            b = $signed(xq);
            c = $signed(yi);
            e = $signed(yq);
            if (cj) begin
                pi = a * c + b * e;
                pq = b * c - a * e;
            end else begin
                pi = a * c - b * e;
                pq = a * e + b * c;
            end
            m_si[d] += pi;
            m_sq[d] += pq;
            m_n[d]++;
            if (m_n[d] == plen[d]) begin
                r.i = clampv(m_si[d] >>> psh[d], pob[d], si);
                r.q = clampv(m_sq[d] >>> psh[d], pob[d], sq);
                r.s = si | sq;
                qpush(d, r);
                m_si[d] = 0;
                m_sq[d] = 0;
                m_n[d]  = 0;
            end
        end
    endtask

    // Inputs change just after posedge, so negedge sees what the next edge takes
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < ND; d++) begin
                m_si[d] = 0;
                m_sq[d] = 0;
                m_n[d]  = 0;
            end
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            sb_step(0, xv & yv & a_rdy, a_v & ptr, $signed(a_i), $signed(a_q), a_s);
            sb_step(1, xv & yv & b_rdy, b_v & ptr, $signed(b_i), $signed(b_q), b_s);
            sb_step(2, xv & yv & c_rdy, c_v & ptr, $signed(c_i), $signed(c_q), c_s);
        end
    end

    typedef struct {
        int       xi, xq, yi, yq;
        bit [4:0] cmask;
        int       ai, aq;
        bit       as;
        int       bi, bq;
        bit       bs;
    } vec_t;

    vec_t tbl[7];

    task automatic drive(input int a, input int b, input int c, input int e, input bit cv);
        xv = 1'b1;
        yv = 1'b1;
        xi = 12'(a);
        xq = 12'(b);
        yi = 12'(c);
        yq = 12'(e);
        cj = cv;
    endtask

    task automatic idle();
        xv = 1'b0;
        yv = 1'b0;
    endtask

    // Five pairs back to back, then watch tvalid for edges E..E+4
    task automatic run_frame(input string tag, input vec_t v);
        for (int k = 0; k < 5; k++) begin
            drive(v.xi, v.xq, v.yi, v.yq, v.cmask[k]);
            @(posedge clk);
            #1;
        end
        idle();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (n == 3) begin
                check({tag, "_tvalid"}, longint'(a_v), 1);
                check({tag, "_a_i"}, $signed(a_i), v.ai);
                check({tag, "_a_q"}, $signed(a_q), v.aq);
                check({tag, "_a_sat"}, longint'(a_s), longint'(v.as));
                check({tag, "_b_i"}, $signed(b_i), v.bi);
                check({tag, "_b_q"}, $signed(b_q), v.bq);
                check({tag, "_b_sat"}, longint'(b_s), longint'(v.bs));
            end else begin
                check($sformatf("%s_tvalid_e%0d", tag, n), longint'(a_v), 0);
            end
        end
    endtask

    initial begin
        tbl[0] = '{100, 0, 100, 0, 5'h00, 50000, 0, 0, 3125, 0, 0};
        tbl[1] = '{3, 4, 3, 4, 5'h00, -35, 120, 0, -3, 7, 0};
        tbl[2] = '{3, 4, 3, 4, 5'h1F, 125, 0, 0, 7, 0, 0};
        tbl[3] = '{3, 4, 3, 4, 5'h0A, 29, 72, 0, 1, 4, 0};
        tbl[4] = '{2047, 0, 2047, 0, 5'h00, 8388607, 0, 1, 32767, 0, 1};
        tbl[5] = '{-2048, -2048, -2048, 2047, 5'h00, 8388607, 10240, 1, 32767, 640, 1};
        tbl[6] = '{2047, 0, -2048, 0, 5'h00, -8388608, 0, 1, -32768, 0, 1};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", longint'(a_v), 0);
        check("rst_i", longint'(a_i), 0);
        check("rst_sat", longint'(a_s), 0);
        check("rst_tready", longint'(a_rdy), 1);
        reset = 1'b0;

        for (int r = 0; r < 7; r++) begin
            run_frame($sformatf("tbl%0d", r), tbl[r]);
        end

        // Partial frame then reset: only the post-reset frame counts
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 1'b0);
            @(posedge clk);
            #1;
        end
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_a_v", longint'(a_v), 0);
        check("mid_rst_a_i", longint'(a_i), 0);
        check("mid_rst_a_q", longint'(a_q), 0);
        check("mid_rst_a_sat", longint'(a_s), 0);
        check("mid_rst_a_rdy", longint'(a_rdy), 1);
        check("mid_rst_b_v", longint'(b_v), 0);
        check("mid_rst_c_v", longint'(c_v), 0);
        check("mid_rst_c_i", longint'(c_i), 0);
        reset = 1'b0;
        run_frame("post_rst", '{1, 0, 1, 0, 5'h00, 5, 0, 0, 0, 0, 0});

        // Back-pressure on the two-product instance
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ptr   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(k + 1, 0, 2, 0, 1'b0);
            @(posedge clk);
            #1;
        end
        check("bp_c_rdy_low", longint'(c_rdy), 0);
        for (int k = 3; k < 8; k++) begin
            drive(k + 1, 0, 2, 0, 1'b0);
            @(posedge clk);
            #1;
        end
        check("bp_c_hold_v", longint'(c_v), 1);
        check("bp_c_hold_rdy", longint'(c_rdy), 0);
        check("bp_c_hold_i", $signed(c_i), 6);
        check("bp_c_hold_q", $signed(c_q), 0);
        check("bp_a_hold_i", $signed(a_i), 30);
        idle();
        ptr = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("bp_c_rdy_back", longint'(c_rdy), 1);
        check("bp_drain_c", q2.size(), 0);

        // Random traffic with independent valids and output stalls
        for (int n = 0; n < 3000; n++) begin
            xv  = ($urandom_range(0, 3) != 0);
            yv  = ($urandom_range(0, 3) != 0);
            xi  = 12'($urandom);
            xq  = 12'($urandom);
            yi  = 12'($urandom);
            yq  = 12'($urandom);
            cj  = 1'($urandom);
            ptr = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        idle();
        ptr = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("rand_drain_a", q0.size(), 0);
        check("rand_drain_b", q1.size(), 0);
        check("rand_drain_c", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
